// File: rtl/fair_sched_pkg.sv
// fair_sched_pkg: shared state type, counter width and saturating increment for fair_sched.
package fair_sched_pkg;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    localparam int CNT_W = 4;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic [CNT_W-1:0] m);
        return (v >= m) ? m : v + 1'b1;
    endfunction

endpackage

// File: rtl/fair_sched_sat_counter.sv
// sat_counter: counter with async reset, sync clear and increment saturating at MAX.
module sat_counter
    import fair_sched_pkg::*;
#(
    parameter logic [CNT_W-1:0] MAX = 4'd15
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)   r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_inc) r_cnt <= sat_inc(r_cnt, MAX);
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/fair_sched.sv
// fair_sched: passes environment select/pause choices through, overriding them to bound
// process starvation and pause run length.
module fair_sched
    import fair_sched_pkg::*;
#(
    parameter int MAX_STARVE = 3,
    parameter int MAX_PAUSE  = 2,
    parameter bit RR_ONLY    = 1'b0
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_enable,
    input  logic             i_nd_select,
    input  logic             i_nd_pause,
    output logic             o_select,
    output logic             o_pause,
    output logic             o_forced,
    output logic [CNT_W-1:0] o_starve0,
    output logic [CNT_W-1:0] o_starve1
);

    localparam logic [CNT_W-1:0] L_MS = CNT_W'(MAX_STARVE);
    localparam logic [CNT_W-1:0] L_MP = CNT_W'(MAX_PAUSE);

    state_t           r_state;
    logic             r_select, r_pause, r_forced;
    logic [CNT_W-1:0] w_pause_run;
    logic             w_step, w_cand, w_sel_forced, w_sel_next, w_pause_forced, w_pause_next;

    assign w_step         = (r_state == RUN) && i_enable;
    assign w_cand         = RR_ONLY ? ~r_select : i_nd_select;
    // the process not proposed gets the slot once it has waited the maximum
    assign w_sel_forced   = ((w_cand ? o_starve0 : o_starve1) == L_MS);
    assign w_sel_next     = w_sel_forced ? ~w_cand : w_cand;
    assign w_pause_forced = (w_pause_run == L_MP);
    assign w_pause_next   = ~w_pause_forced & i_nd_pause;

    sat_counter #(.MAX(L_MS)) u_starve0 (
        .i_clk(i_clock), .i_rst_n(i_reset_n),
        .i_clr(w_step & ~w_sel_next), .i_inc(w_step & w_sel_next), .o_cnt(o_starve0)
    );

    sat_counter #(.MAX(L_MS)) u_starve1 (
        .i_clk(i_clock), .i_rst_n(i_reset_n),
        .i_clr(w_step & w_sel_next), .i_inc(w_step & ~w_sel_next), .o_cnt(o_starve1)
    );

    sat_counter #(.MAX(L_MP)) u_pause_run (
        .i_clk(i_clock), .i_rst_n(i_reset_n),
        .i_clr(w_step & ~w_pause_next), .i_inc(w_step & w_pause_next), .o_cnt(w_pause_run)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= IDLE;
            r_select <= 1'b0;
            r_pause  <= 1'b1;
            r_forced <= 1'b0;
        end else begin
            case (r_state)
                IDLE: r_state <= RUN;
                RUN: begin
                    if (!i_enable) begin
                        r_state <= HOLD;
                    end else begin
                        r_select <= w_sel_next;
                        r_pause  <= w_pause_next;
                        r_forced <= w_sel_forced | w_pause_forced;
                    end
                end
                HOLD: if (i_enable) r_state <= RUN;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_select = r_select;
    assign o_pause  = r_pause;
    assign o_forced = r_forced;

endmodule

// File: tb/tb_fair_sched.sv
// tb_fair_sched: checks a free-choice and a round-robin fair_sched against a step-level reference model.
module tb_fair_sched;

    localparam int MS = 3;
    localparam int MP = 2;

    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, nds = 1'b0, ndp = 1'b0;
    logic       o_sel[2], o_pse[2], o_frc[2];
    logic [3:0] o_s0[2], o_s1[2];

    int n_cmp = 0, n_bad = 0;

    // reference: mode 0=idle 1=run 2=hold; st[p] = steps since process p was last chosen
    int m_mode[2], m_sel[2], m_pse[2], m_frc[2], m_pr[2], run_p[2];
    int m_st[2][2];

    typedef struct {
        logic en, nds, ndp;
        int   sel, pse, frc, s0, s1;
    } vec_t;
    vec_t tbl[9];

    always #5 clk = ~clk;

    fair_sched #(.MAX_STARVE(MS), .MAX_PAUSE(MP), .RR_ONLY(1'b0)) dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_enable(en), .i_nd_select(nds), .i_nd_pause(ndp),
        .o_select(o_sel[0]), .o_pause(o_pse[0]), .o_forced(o_frc[0]),
        .o_starve0(o_s0[0]), .o_starve1(o_s1[0])
    );

    fair_sched #(.MAX_STARVE(MS), .MAX_PAUSE(MP), .RR_ONLY(1'b1)) dut_rr (
        .i_clock(clk), .i_reset_n(rst_n), .i_enable(en), .i_nd_select(nds), .i_nd_pause(ndp),
        .o_select(o_sel[1]), .o_pause(o_pse[1]), .o_forced(o_frc[1]),
        .o_starve0(o_s0[1]), .o_starve1(o_s1[1])
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_sel[k] = 0; m_pse[k] = 1; m_frc[k] = 0;
            m_pr[k] = 0; run_p[k] = 0; m_st[k][0] = 0; m_st[k][1] = 0;
        end
    endtask

    task automatic model_step(input int k);
        int c, s, p, fs, fp;
        if (m_mode[k] == 0) m_mode[k] = 1;
        else if (m_mode[k] == 2) begin
            if (en) m_mode[k] = 1;
        end else if (!en) m_mode[k] = 2;
        else begin
            c  = (k == 1) ? 1 - m_sel[k] : int'(nds);
            fs = (m_st[k][1-c] >= MS) ? 1 : 0;
            s  = fs ? 1 - c : c;
            fp = (m_pr[k] >= MP) ? 1 : 0;
            p  = fp ? 0 : int'(ndp);
            m_st[k][s]   = 0;
            m_st[k][1-s] = (m_st[k][1-s] + 1 > MS) ? MS : m_st[k][1-s] + 1;
            m_pr[k]      = p ? ((m_pr[k] + 1 > MP) ? MP : m_pr[k] + 1) : 0;
            m_sel[k] = s; m_pse[k] = p; m_frc[k] = fs | fp;
        end
    endtask

    task automatic check_model(input int k);
        chk($sformatf("k%0d select", k), int'(o_sel[k]), m_sel[k]);
        chk($sformatf("k%0d pause", k),  int'(o_pse[k]), m_pse[k]);
        chk($sformatf("k%0d forced", k), int'(o_frc[k]), m_frc[k]);
        chk($sformatf("k%0d starve0", k), int'(o_s0[k]), m_st[k][0]);
        chk($sformatf("k%0d starve1", k), int'(o_s1[k]), m_st[k][1]);
    endtask

    task automatic check_inv(input int k, input bit stepped);
        int lim;
        lim = (k == 1) ? 1 : MS;
        chk($sformatf("k%0d starve0 bound", k), int'(o_s0[k] <= lim), 1);
        chk($sformatf("k%0d starve1 bound", k), int'(o_s1[k] <= lim), 1);
        if (stepped) begin
            chk($sformatf("k%0d one starve zero", k), int'(o_s0[k] == 0 || o_s1[k] == 0), 1);
            run_p[k] = o_pse[k] ? run_p[k] + 1 : 0;
            chk($sformatf("k%0d pause run bound", k), int'(run_p[k] <= MP), 1);
        end
    endtask

    task automatic tick();
        bit stepped[2];
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            stepped[k] = (m_mode[k] == 1) && en;
            model_step(k);
        end
        #2;
        for (int k = 0; k < 2; k++) begin
            check_model(k);
            check_inv(k, stepped[k]);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s k%0d select", tag, k), int'(o_sel[k]), 0);
            chk($sformatf("%s k%0d pause", tag, k), int'(o_pse[k]), 1);
            chk($sformatf("%s k%0d forced", tag, k), int'(o_frc[k]), 0);
            chk($sformatf("%s k%0d starve0", tag, k), int'(o_s0[k]), 0);
            chk($sformatf("%s k%0d starve1", tag, k), int'(o_s1[k]), 0);
        end
    endtask

    // asynchronous pulse placed between clock edges
    task automatic pulse_reset(input string tag);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals(tag);
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b1, 0, 1, 0, 0, 0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 0, 1, 0, 0, 1};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 0, 1, 0, 0, 2};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 0, 0, 1, 0, 3};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1, 1, 1, 1, 0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 0, 1, 0, 0, 1};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 0, 0, 1, 0, 2};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 0, 1, 0, 0, 3};
        tbl[8] = '{1'b1, 1'b0, 1'b1, 1, 1, 1, 1, 0};

        model_reset();
        #12;
        check_reset_vals("por");
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            en = tbl[i].en; nds = tbl[i].nds; ndp = tbl[i].ndp;
            tick();
            chk($sformatf("tbl%0d select", i), int'(o_sel[0]), tbl[i].sel);
            chk($sformatf("tbl%0d pause", i), int'(o_pse[0]), tbl[i].pse);
            chk($sformatf("tbl%0d forced", i), int'(o_frc[0]), tbl[i].frc);
            chk($sformatf("tbl%0d starve0", i), int'(o_s0[0]), tbl[i].s0);
            chk($sformatf("tbl%0d starve1", i), int'(o_s1[0]), tbl[i].s1);
        end

        // hold with starve1=2, then resume
        pulse_reset("hold rst");
        en = 1'b1; nds = 1'b0; ndp = 1'b0;
        repeat (3) tick();
        chk("hold pre starve1", int'(o_s1[0]), 2);
        en = 1'b0;
        repeat (5) begin
            tick();
            chk("hold starve1", int'(o_s1[0]), 2);
            chk("hold select", int'(o_sel[0]), 0);
            chk("hold forced", int'(o_frc[0]), 0);
        end
        en = 1'b1;
        tick();
        chk("resume edge starve1", int'(o_s1[0]), 2);
        tick();
        chk("resume select", int'(o_sel[0]), 0);
        chk("resume starve1", int'(o_s1[0]), 3);
        tick();
        chk("resume forced select", int'(o_sel[0]), 1);
        chk("resume forced", int'(o_frc[0]), 1);
        chk("resume starve1 clr", int'(o_s1[0]), 0);

        // mid-run reset with starve0=3 and pause run at its limit
        pulse_reset("mid rst a");
        en = 1'b1; nds = 1'b1; ndp = 1'b0;
        tick();
        tick();
        ndp = 1'b1;
        tick();
        tick();
        chk("pre-reset starve0", int'(o_s0[0]), 3);
        chk("pre-reset pause", int'(o_pse[0]), 1);
        pulse_reset("mid rst b");
        tick();
        check_reset_vals("post idle edge");

        // long random run, occasional reset
        for (int i = 0; i < 10000; i++) begin
            en  = ($urandom_range(9) != 0);
            nds = 1'($urandom);
            ndp = 1'($urandom);
            if ($urandom_range(999) == 0) pulse_reset("rand rst");
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
